// File: rtl/fib_pkg.sv
// Shared types and defaults for the Fibonacci engine scheduler.
package fib_pkg;
   localparam int FIB_W       = 32;
   localparam int FIB_TIMEOUT = 256;

   typedef enum logic [2:0] {
      IDLE,
      GRANT,
      START,
      WAIT_LOW,
      WAIT_HIGH,
      RESP
   } state_t;
endpackage

// File: rtl/fib_rr_arb.sv
// Combinational round-robin arbiter: first set request at or above ptr, wrapping.
module fib_rr_arb #(
   parameter int NREQ = 4,
   parameter int IDW  = 2
) (
   input  logic [NREQ-1:0] req,
   input  logic [IDW-1:0]  ptr,
   input  logic            en,
   output logic [IDW-1:0]  win,
   output logic            win_valid
);
   logic [2*NREQ-1:0] req_dbl;
   logic [NREQ-1:0]   rot;
   logic [IDW:0]      sum;

   // Rotating a doubled copy puts requester ptr at bit 0 without a modulo index.
   assign req_dbl = {req, req};
   assign rot     = NREQ'(req_dbl >> ptr);

   always_comb begin
      sum       = '0;
      win_valid = 1'b0;
      for (int k = NREQ - 1; k >= 0; k--) begin
         if (rot[k]) begin
            sum       = {1'b0, ptr} + (IDW + 1)'(k);
            win_valid = en;
         end
      end
      if (sum >= (IDW + 1)'(NREQ)) begin
         sum = sum - (IDW + 1)'(NREQ);
      end
      win = sum[IDW-1:0];
   end
endmodule

// File: rtl/fib_sched.sv
// Round-robin scheduler sharing one Fibonacci engine among NREQ requesters,
// with a watchdog that turns a hung engine into an error response.
module fib_sched
   import fib_pkg::*;
#(
   parameter int W       = FIB_W,
   parameter int NREQ    = 4,
   parameter int IDW     = 2,
   parameter int TIMEOUT = FIB_TIMEOUT
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic [NREQ-1:0]   req_valid,
   input  logic [NREQ*W-1:0] req_n,
   output logic [NREQ-1:0]   req_ready,
   output logic              rsp_valid,
   output logic [IDW-1:0]    rsp_id,
   output logic [W-1:0]      rsp_fibn,
   output logic              rsp_err,
   input  logic              rsp_ready,
   output logic [W-1:0]      eng_n,
   output logic              eng_start,
   input  logic [W-1:0]      eng_fibn,
   input  logic              eng_done
);
   localparam int WDW   = $clog2(TIMEOUT) + 1;
   localparam int NSLOT = 2 ** IDW;
   localparam logic [WDW-1:0] WD_LAST = WDW'(TIMEOUT - 1);

   state_t          state;
   logic [IDW-1:0]  ptr;
   logic [IDW-1:0]  win;
   logic            win_valid;
   logic            arb_en;
   logic [WDW-1:0]  wdog;
   logic [WDW-1:0]  wdog_inc;
   logic [NREQ-1:0] win_onehot;
   logic [W-1:0]    slot_n [NSLOT];

   genvar gi;
   generate
      for (gi = 0; gi < NSLOT; gi++) begin : g_slot
         if (gi < NREQ) begin : g_used
            assign slot_n[gi] = req_n[gi*W +: W];
         end else begin : g_unused
            assign slot_n[gi] = '0;
         end
      end
      for (gi = 0; gi < NREQ; gi++) begin : g_onehot
         assign win_onehot[gi] = (win == IDW'(gi));
      end
   endgenerate

   // Arbitrate only when a grant is actually possible (idle and engine free).
   assign arb_en   = (state == IDLE) && eng_done;
   assign wdog_inc = (wdog == '1) ? wdog : wdog + 1'b1;

   fib_rr_arb #(
      .NREQ(NREQ),
      .IDW (IDW)
   ) u_arb (
      .req      (req_valid),
      .ptr      (ptr),
      .en       (arb_en),
      .win      (win),
      .win_valid(win_valid)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= IDLE;
         ptr       <= '0;
         wdog      <= '0;
         req_ready <= '0;
         rsp_valid <= 1'b0;
         rsp_id    <= '0;
         rsp_fibn  <= '0;
         rsp_err   <= 1'b0;
         eng_n     <= '0;
         eng_start <= 1'b0;
      end else begin
         req_ready <= '0;
         eng_start <= 1'b0;
         case (state)
            IDLE: begin
               if (win_valid) begin
                  req_ready <= win_onehot;
                  eng_n     <= slot_n[win];
                  rsp_id    <= win;
                  ptr       <= (win == IDW'(NREQ - 1)) ? '0 : win + 1'b1;
                  state     <= GRANT;
               end
            end
            GRANT: begin
               eng_start <= 1'b1;
               state     <= START;
            end
            START: begin
               wdog  <= '0;
               state <= WAIT_LOW;
            end
            WAIT_LOW: begin
               if (!eng_done) begin
                  wdog  <= wdog_inc;
                  state <= WAIT_HIGH;
               end else if (wdog != '0) begin
                  // Done never dropped: the engine finished with zero latency.
                  rsp_fibn  <= eng_fibn;
                  rsp_err   <= 1'b0;
                  rsp_valid <= 1'b1;
                  state     <= RESP;
               end else begin
                  wdog <= wdog_inc;
               end
            end
            WAIT_HIGH: begin
               if (eng_done) begin
                  rsp_fibn  <= eng_fibn;
                  rsp_err   <= 1'b0;
                  rsp_valid <= 1'b1;
                  state     <= RESP;
               end else if (wdog == WD_LAST) begin
                  rsp_fibn  <= '0;
                  rsp_err   <= 1'b1;
                  rsp_valid <= 1'b1;
                  state     <= RESP;
               end else begin
                  wdog <= wdog_inc;
               end
            end
            RESP: begin
               if (rsp_ready) begin
                  rsp_valid <= 1'b0;
                  state     <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_fib_sched.sv
// Self-checking bench for fib_sched: behavioural engine, round-robin/response model, directed and random traffic.
module tb_fib_sched;
   localparam int W       = 32;
   localparam int NREQ    = 4;
   localparam int IDW     = 2;
   localparam int TIMEOUT = 256;

   logic              clk = 1'b0;
   logic              rst_n;
   logic [NREQ-1:0]   req_valid;
   logic [NREQ*W-1:0] req_n;
   logic [NREQ-1:0]   req_ready;
   logic              rsp_valid;
   logic [IDW-1:0]    rsp_id;
   logic [W-1:0]      rsp_fibn;
   logic              rsp_err;
   logic              rsp_ready;
   logic [W-1:0]      eng_n;
   logic              eng_start;
   logic [W-1:0]      eng_fibn;
   logic              eng_done;

   fib_sched #(.W(W), .NREQ(NREQ), .IDW(IDW), .TIMEOUT(TIMEOUT)) dut (
      .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_n(req_n),
      .req_ready(req_ready), .rsp_valid(rsp_valid), .rsp_id(rsp_id),
      .rsp_fibn(rsp_fibn), .rsp_err(rsp_err), .rsp_ready(rsp_ready),
      .eng_n(eng_n), .eng_start(eng_start), .eng_fibn(eng_fibn), .eng_done(eng_done)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", name, got, exp);
      end
   endtask

   function automatic logic [31:0] fib(input logic [31:0] n);
      logic [31:0] a, b, t;
      if (n > 1000) return 32'hdead;
      a = 0;
      b = 1;
      for (int i = 0; i < int'(n); i++) begin
         t = a + b;
         a = b;
         b = t;
      end
      return a;
   endfunction

   function automatic int rr(input logic [NREQ-1:0] v, input int p);
      for (int k = 0; k < NREQ; k++) begin
         if (v[(p + k) % NREQ]) return (p + k) % NREQ;
      end
      return -1;
   endfunction

   // Engine control knobs (written by the stimulus process only)
   bit hang_next = 0, hang_release = 0, rand_eng = 0;
   int fix_lat = 3;

   // Behavioural engine: done high when idle, drops within 2 cycles of start.
   initial begin : engine
      logic [31:0] en;
      bit hg, zm, dly;
      int lat;
      eng_done = 1'b1;
      eng_fibn = '0;
      forever begin
         @(negedge clk);
         if (eng_start && eng_done) begin
            en  = eng_n;
            hg  = hang_next;
            zm  = rand_eng && ($urandom_range(0, 9) == 0);
            lat = rand_eng ? int'($urandom_range(1, 8)) : fix_lat;
            dly = rand_eng && ($urandom_range(0, 1) == 1);
            @(posedge clk); #1;
            if (zm) begin
               eng_fibn = fib(en);
            end else begin
               if (dly) begin
                  @(posedge clk); #1;
               end
               eng_done = 1'b0;
               eng_fibn = $urandom;
               if (hg) begin
                  wait (hang_release);
                  @(posedge clk); #1;
               end else begin
                  repeat (lat) @(posedge clk);
                  #1;
               end
               eng_fibn = fib(en);
               eng_done = 1'b1;
            end
         end
      end
   end

   // Reference model and per-cycle compare process
   int cyc = 0, ptr_m = 0, mw, exp_id, start_cyc = 0, valid_cyc = 0;
   int nstart_txn = 0, nstart_total = 0;
   bit outstanding = 0, exp_err, in_wait = 0, need_rsp = 0, seen_valid = 0;
   logic [31:0] exp_n, exp_fib;
   logic [NREQ-1:0] prev_valid = '0;
   bit prev_done = 1, prev_rv = 0, prev_rr = 0, prev_err = 0;
   logic [IDW-1:0] prev_id = '0;
   logic [31:0] prev_fib = '0;
   int g_log[$];
   int r_id[$];
   logic [31:0] r_fib[$];
   bit r_err[$];
   int r_lat[$];

   always @(negedge clk) begin
      cyc++;
      if (!rst_n) begin
         ptr_m = 0; outstanding = 0; in_wait = 0; need_rsp = 0;
         seen_valid = 0; nstart_txn = 0; prev_rv = 0; prev_rr = 0;
      end else begin
         if (eng_start) begin
            nstart_txn++;
            nstart_total++;
            chk("start_while_engine_busy", eng_done, 1);
            chk("start_pulses_per_txn", nstart_txn, 1);
            chk("start_operand", eng_n, exp_n);
            chk("start_has_txn", outstanding, 1);
            in_wait = 1;
            start_cyc = cyc;
         end
         if (need_rsp) begin
            chk("rsp_latency_after_done", rsp_valid, 1);
            need_rsp = 0;
         end
         if (in_wait && !prev_done && eng_done && !rsp_valid) need_rsp = 1;
         if (req_ready != '0) begin
            mw = rr(prev_valid, ptr_m);
            chk("grant_onehot", req_ready, (mw < 0) ? 64'd0 : (64'd1 << mw));
            chk("grant_engine_idle", prev_done, 1);
            chk("grant_single_outstanding", outstanding, 0);
            if (mw >= 0) begin
               g_log.push_back(mw);
               ptr_m   = (mw + 1) % NREQ;
               exp_id  = mw;
               exp_n   = req_n[mw*W +: W];
               exp_err = hang_next;
               exp_fib = hang_next ? 32'd0 : fib(exp_n);
            end
            outstanding = 1;
            nstart_txn  = 0;
            seen_valid  = 0;
         end
         if (prev_rv && prev_rr) begin
            chk("rsp_drop_after_handshake", rsp_valid, 0);
         end else if (prev_rv) begin
            chk("rsp_hold_valid", rsp_valid, 1);
            chk("rsp_hold_id", rsp_id, prev_id);
            chk("rsp_hold_fibn", rsp_fibn, prev_fib);
            chk("rsp_hold_err", rsp_err, prev_err);
         end
         if (rsp_valid) begin
            if (!seen_valid) begin
               seen_valid = 1;
               valid_cyc  = cyc;
               in_wait    = 0;
               chk("rsp_has_txn", outstanding, 1);
            end
            if (rsp_ready) begin
               chk("rsp_id", rsp_id, exp_id);
               chk("rsp_fibn", rsp_fibn, exp_fib);
               chk("rsp_err", rsp_err, exp_err);
               $display("txn id=%0d n=%0d fibn=%0d err=%0d", rsp_id, exp_n, rsp_fibn, rsp_err);
               r_id.push_back(int'(rsp_id));
               r_fib.push_back(rsp_fibn);
               r_err.push_back(rsp_err);
               r_lat.push_back(valid_cyc - start_cyc);
               outstanding = 0;
            end
         end
         prev_rv  = rsp_valid;
         prev_rr  = rsp_ready;
         prev_id  = rsp_id;
         prev_fib = rsp_fibn;
         prev_err = rsp_err;
      end
      prev_valid = req_valid;
      prev_done  = eng_done;
   end

   // Stimulus helpers
   bit cont [NREQ];
   bit rand_rdy = 0;

   task automatic step();
      logic [NREQ-1:0] taken;
      @(negedge clk);
      taken = req_ready & req_valid;
      @(posedge clk); #1;
      for (int i = 0; i < NREQ; i++) begin
         if (taken[i] && !cont[i]) req_valid[i] = 1'b0;
      end
      if (rand_rdy) rsp_ready = ($urandom_range(0, 3) != 0);
   endtask

   task automatic post(input int i, input logic [31:0] n);
      req_n[i*W +: W] = n;
      req_valid[i] = 1'b1;
   endtask

   task automatic wait_quiet(input int budget);
      int k = 0;
      while (k < budget && !(req_valid == '0 && !outstanding && !rsp_valid)) begin
         step();
         k++;
      end
      chk("quiet_within_budget", (k < budget), 1);
   endtask

   task automatic chk_reset(input string tag);
      chk({tag, "_req_ready"}, req_ready, 0);
      chk({tag, "_rsp_valid"}, rsp_valid, 0);
      chk({tag, "_rsp_id"}, rsp_id, 0);
      chk({tag, "_rsp_fibn"}, rsp_fibn, 0);
      chk({tag, "_rsp_err"}, rsp_err, 0);
      chk({tag, "_eng_n"}, eng_n, 0);
      chk({tag, "_eng_start"}, eng_start, 0);
   endtask

   initial begin : watchdog
      #1_500_000;
      $display("FAIL global_timeout: simulation did not finish");
      $fatal(1, "global timeout");
   end

   initial begin : stim
      int base, rbase, k, s0, lat;
      int order [5] = '{0, 1, 2, 3, 0};
      logic [31:0] rr_fib [5] = '{55, 6765, 1, 0, 55};
      logic [31:0] nv [4] = '{10, 20, 1, 0};

      rst_n = 1'b0; req_valid = '0; req_n = '0; rsp_ready = 1'b1;
      for (int i = 0; i < NREQ; i++) cont[i] = 0;
      repeat (3) @(posedge clk);
      #1;
      chk_reset("reset");
      #2 rst_n = 1'b1;
      @(posedge clk); #1;

      // Four continuous requesters from a fresh pointer
      base = g_log.size(); rbase = r_id.size();
      for (int i = 0; i < NREQ; i++) begin
         cont[i] = 1;
         post(i, nv[i]);
      end
      k = 0;
      while (g_log.size() < base + 5 && k < 500) begin
         step();
         k++;
      end
      for (int i = 0; i < NREQ; i++) cont[i] = 0;
      req_valid = '0;
      wait_quiet(300);
      chk("rr_grant_count", g_log.size() - base, 5);
      chk("rr_rsp_count", r_id.size() - rbase, 5);
      for (int i = 0; i < 5; i++) begin
         chk("rr_grant_order", g_log[base+i], order[i]);
         chk("rr_rsp_id", r_id[rbase+i], order[i]);
         chk("rr_rsp_fibn", r_fib[rbase+i], rr_fib[i]);
      end

      // Single request
      post(2, 30);
      wait_quiet(200);
      chk("single_grant", g_log[$], 2);
      chk("single_id", r_id[$], 2);
      chk("single_fibn", r_fib[$], 832040);
      chk("single_err", r_err[$], 0);

      // Modular wrap of the result
      post(1, 50);
      wait_quiet(200);
      chk("wrap_fibn", r_fib[$], 64'd3996334433);

      // Response backpressure
      rsp_ready = 1'b0;
      post(3, 7);
      k = 0;
      while (!rsp_valid && k < 100) begin
         step();
         k++;
      end
      chk("bp_rsp_seen", rsp_valid, 1);
      s0 = nstart_total;
      repeat (20) step();
      chk("bp_valid_held", rsp_valid, 1);
      chk("bp_fibn_held", rsp_fibn, 13);
      chk("bp_no_new_start", nstart_total, s0);
      rsp_ready = 1'b1;
      step();
      chk("bp_valid_drop", rsp_valid, 0);
      wait_quiet(50);

      // Watchdog timeout, then no grant until the engine recovers
      hang_next = 1;
      post(0, 5);
      wait_quiet(TIMEOUT + 100);
      lat = r_lat[$];
      chk("timeout_err", r_err[$], 1);
      chk("timeout_fibn", r_fibn_last(), 0);
      chk("timeout_latency_in_range", (lat >= TIMEOUT && lat <= TIMEOUT + 2), 1);
      hang_next = 0;
      base = g_log.size();
      post(1, 3);
      repeat (20) step();
      chk("no_grant_while_engine_busy", g_log.size(), base);
      hang_release = 1;
      wait_quiet(100);
      hang_release = 0;
      chk("post_timeout_grant", g_log[$], 1);
      chk("post_timeout_fibn", r_fib[$], 2);
      chk("post_timeout_err", r_err[$], 0);

      // Asynchronous reset while waiting on a slow engine
      fix_lat = 40;
      s0 = nstart_total;
      post(2, 9);
      k = 0;
      while (nstart_total == s0 && k < 50) begin
         step();
         k++;
      end
      repeat (5) step();
      #2 rst_n = 1'b0;
      #1 chk_reset("async_reset");
      req_valid = '0;
      repeat (2) @(posedge clk);
      #3 rst_n = 1'b1;
      @(posedge clk); #1;
      fix_lat = 3;
      base = g_log.size(); rbase = r_id.size();
      post(3, 4);
      post(1, 6);
      wait_quiet(300);
      chk("post_reset_grants", g_log.size() - base, 2);
      chk("post_reset_first_grant", g_log[base], 1);
      chk("post_reset_second_grant", g_log[base+1], 3);
      chk("post_reset_fib_1", r_fib[rbase], 8);
      chk("post_reset_fib_3", r_fib[rbase+1], 3);

      // Randomised traffic
      rand_eng = 1;
      rand_rdy = 1;
      for (int c = 0; c < 3000; c++) begin
         for (int i = 0; i < NREQ; i++) begin
            if (!req_valid[i] && $urandom_range(0, 7) == 0) post(i, $urandom_range(0, 90));
         end
         step();
      end
      rand_rdy = 0;
      rsp_ready = 1'b1;
      wait_quiet(1000);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   function automatic logic [31:0] r_fibn_last();
      return (r_fib.size() > 0) ? r_fib[r_fib.size()-1] : 32'hffff_ffff;
   endfunction
endmodule

// File: doc/fib_sched.md
Name: fib_sched

Overview:
- Round-robin scheduler that shares one fast-doubling Fibonacci engine among NREQ requesters.
- Accepts one request at a time over a valid/ready handshake and drives the engine's n/start inputs.
- Watches the engine's done level and returns the result, tagged with the requester id, on a single shared response channel.
- Includes a watchdog so that a hung engine cannot deadlock the requesters.

Parameters:
- W, 32: operand/result width; matches the engine width.
- NREQ, 4: number of requesters, 2..16.
- IDW, 2: id width; must satisfy 2**IDW >= NREQ.
- TIMEOUT, 256: maximum cycles from start to done before an error response is returned.

Ports:
- clk  in  1  single clock, rising edge.
- rst_n  in  1  reset; see Behaviour.
- req_valid  in  NREQ  per-requester request valid.
- req_n  in  NREQ*W  packed operands; requester i occupies bits [i*W +: W].
- req_ready  out  NREQ  one-hot accept pulse.
- rsp_valid  out  1  response valid.
- rsp_id  out  IDW  index of the requester that owns the response.
- rsp_fibn  out  W  result, fib(n) mod 2**W.
- rsp_err  out  1  1 = watchdog timeout; rsp_fibn is then 0.
- rsp_ready  in  1  response consumer ready.
- eng_n  out  W  engine operand.
- eng_start  out  1  engine start, one-cycle pulse.
- eng_fibn  in  W  engine result.
- eng_done  in  1  engine idle/result-valid level.

Behaviour:
- Clock and reset: one clock (clk); reset rst_n is asynchronous, active-low. Assertion takes effect immediately with no clock edge. Deassertion is synchronised externally.
- Reset values:
  - State: IDLE.
  - Outputs: req_ready=0, rsp_valid=0, rsp_id=0, rsp_fibn=0, rsp_err=0, eng_n=0, eng_start=0.
  - Round-robin pointer=0; watchdog counter=0.
- Reset mid-operation: an in-flight request and any pending response are discarded. Requesters must reissue.
- Engine contract:
  - eng_done is high when the engine is idle.
  - eng_start is sampled only while eng_done=1.
  - eng_done falls within 2 cycles of start and returns high with eng_fibn valid.
- FSM states: IDLE, GRANT, START, WAIT_LOW, WAIT_HIGH, RESP.
  - IDLE: when any req_valid bit is set and eng_done=1, go to GRANT. If eng_done=0 (engine busy at reset exit), stay in IDLE.
  - GRANT:
    - Select the winner: the first set req_valid bit searching upward from pointer and wrapping at NREQ-1 to 0.
    - Pulse req_ready[winner] for exactly 1 cycle.
    - Latch req_n slice into eng_n and the winner into the id register.
    - Set pointer = winner+1 (mod NREQ).
    - Next state is START.
    - The request is consumed only in this cycle. If the requester dropped valid (which it must not do), the latched n is still used.
  - START: eng_start=1 for 1 cycle; clear the watchdog; go to WAIT_LOW.
  - WAIT_LOW: wait for eng_done=0. If eng_done is still 1 after 2 cycles, treat it as a zero-latency completion and go to RESP with eng_fibn. This covers an engine that finishes n=0 immediately.
  - WAIT_HIGH: on eng_done=1, capture eng_fibn into rsp_fibn with rsp_err=0, then go to RESP.
  - Watchdog: counts every cycle in WAIT_LOW and WAIT_HIGH. On reaching TIMEOUT-1, force rsp_err=1 and rsp_fibn=0, then go to RESP. The engine is not reset.
  - RESP:
    - Hold rsp_valid=1 and keep rsp_id/rsp_fibn/rsp_err stable until rsp_ready=1.
    - On the handshake cycle, rsp_valid falls next cycle and the state returns to IDLE.
    - After a timeout, IDLE waits for eng_done=1 before any new grant.
- Latency:
  - Request accept: req_ready asserts 1 cycle after req_valid is seen in IDLE.
  - Response: rsp_valid asserts 1 cycle after eng_done rises.
- Throughput: one outstanding request. Back-to-back requests cost 3 overhead cycles plus engine time.
- Simultaneous requests: exactly one grant per transaction; fairness is strict round-robin.
- The scheduler never asserts eng_start while eng_done=0.
- Width rules: no arithmetic beyond the watchdog counter, which is $clog2(TIMEOUT)+1 bits and saturates.

Decomposition:
- Shared package fib_pkg: FSM state enum, default W, and the TIMEOUT constant.
- One sub-module, fib_rr_arb: NREQ-wide round-robin arbiter. Inputs are req vector, pointer and an enable; output is the winner index plus a valid flag. It is purely combinational.
- The pointer register stays in fib_sched.

Test Plan:
- Single request: requester 2 sends n=30 → one req_ready[2] pulse, one eng_start pulse with eng_n=30. Response rsp_id=2, rsp_fibn=832040, rsp_err=0.
- All four requesters continuously valid with n=10,20,1,0 → grant order 0,1,2,3,0. Responses 55, 6765, 1, 0 with matching ids.
- Backpressure: rsp_ready held 0 for 20 cycles after rsp_valid → rsp_* stable throughout, no new eng_start. One cycle after rsp_ready=1, rsp_valid=0.
- Timeout: engine model never raises eng_done → after TIMEOUT cycles, rsp_err=1 and rsp_fibn=0. No grant until eng_done returns to 1.
- Reset in WAIT_HIGH: rst_n=0 asynchronously → all outputs reach reset values before the next clk edge. After release, the pointer is 0 and the next grant goes to the lowest valid requester.
- Wrap/overflow: n=50, W=32 → rsp_fibn=12586269025 mod 2**32=3996334433.
